// File: rtl/exp_adjust_pipe_pkg.sv
// Shared constants and stage bundles for the exponent adjust pipeline.
package exp_adjust_pipe_pkg;

    localparam int BFP16_EXP_W = 8;
    localparam int BFP16_MAN_W = 7;
    localparam logic [BFP16_EXP_W-1:0] BFP16_EXP_ONES = '1;

    // Holds the widest legal exponent plus sign and carry headroom.
    localparam int RAW_W_MAX = 14;

    typedef struct packed {
        logic [RAW_W_MAX-1:0] raw;
        logic                 zero;
    } s1_t;

endpackage

// File: rtl/exp_adjust_pipe_if.sv
// Operand/result handshake bundle for exp_adjust_pipe.
interface exp_adjust_pipe_if
    import exp_adjust_pipe_pkg::*;
#(
    parameter int SIZE_EXP  = BFP16_EXP_W,
    parameter int SIZE_LOPD = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_overflow;
    logic                 i_underflow;
    logic                 i_zero_flag;
    logic [SIZE_LOPD-1:0] i_lopd_value;
    logic [SIZE_EXP-1:0]  i_exp_value;
    logic                 o_valid;
    logic                 i_ready;
    logic [SIZE_EXP-1:0]  o_exp_result;
    logic                 o_ovf;
    logic                 o_unf;
    logic                 i_clr_sticky;
    logic                 o_sticky_ovf;
    logic                 o_sticky_unf;

    modport master (
        output i_valid, i_overflow, i_underflow, i_zero_flag,
        output i_lopd_value, i_exp_value, i_ready, i_clr_sticky,
        input  o_ready, o_valid, o_exp_result, o_ovf, o_unf,
        input  o_sticky_ovf, o_sticky_unf
    );

    modport slave (
        input  i_valid, i_overflow, i_underflow, i_zero_flag,
        input  i_lopd_value, i_exp_value, i_ready, i_clr_sticky,
        output o_ready, o_valid, o_exp_result, o_ovf, o_unf,
        output o_sticky_ovf, o_sticky_unf
    );

endinterface

// File: rtl/exp_adjust_pipe_cla_nbit.sv
// N-bit carry-lookahead adder; every carry is formed directly from g/p.
module cla_nbit #(
    parameter int N = 10
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] sum_o
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin : carry_la
        logic acc;
        c    = '0;
        c[0] = c_i;
        for (int i = 1; i < N; i++) begin
            acc = c_i;
            for (int j = 0; j < i; j++) begin
                acc = g[j] | (p[j] & acc);
            end
            c[i] = acc;
        end
    end

    assign sum_o = p ^ c;

endmodule

// File: rtl/exp_adjust_pipe.sv
// Two-stage exponent adjust: S1 raw add/sub, S2 saturate and flag.
module exp_adjust_pipe
    import exp_adjust_pipe_pkg::*;
#(
    parameter int SIZE_EXP  = BFP16_EXP_W,
    parameter int SIZE_LOPD = 8
) (
    input logic              i_clk,
    input logic              i_rst_n,
    exp_adjust_pipe_if.slave bus
);
    localparam int RW = SIZE_EXP + 2;
    localparam logic signed [RAW_W_MAX-1:0] RAW_SAT =
        RAW_W_MAX'((2 ** SIZE_EXP) - 1);

    logic [RW-1:0] a_op;
    logic [RW-1:0] b_op;
    logic [RW-1:0] sum;
    logic          cin;

    logic                 s1_full_q, s1_full_d;
    logic                 s2_full_q, s2_full_d;
    s1_t                  s1_q, s1_d;
    logic [SIZE_EXP-1:0]  exp_q, exp_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 sticky_ovf_q, sticky_ovf_d;
    logic                 sticky_unf_q, sticky_unf_d;
    logic                 s2_move, s2_load, s1_move;
    logic                 ready, in_xfer;
    logic signed [RAW_W_MAX-1:0] raw_s;

    // Overflow wins over underflow; subtraction is a + ~b + 1.
    always_comb begin
        a_op = RW'(bus.i_exp_value);
        b_op = '0;
        cin  = 1'b0;
        if (bus.i_overflow) begin
            cin = 1'b1;
        end else if (!bus.i_underflow) begin
            b_op = ~RW'(bus.i_lopd_value);
            cin  = 1'b1;
        end
    end

    cla_nbit #(.N(RW)) u_cla (
        .a_i  (a_op),
        .b_i  (b_op),
        .c_i  (cin),
        .sum_o(sum)
    );

    assign s2_move = s2_full_q & bus.i_ready;
    assign s2_load = !s2_full_q | s2_move;
    assign s1_move = s1_full_q & s2_load;
    assign ready   = !s1_full_q | s2_load;
    assign in_xfer = bus.i_valid & ready;
    assign raw_s   = $signed(s1_q.raw);

    always_comb begin
        s1_full_d = s1_full_q;
        s1_d      = s1_q;
        if (in_xfer) begin
            s1_full_d = 1'b1;
            s1_d.raw  = RAW_W_MAX'($signed(sum));
            s1_d.zero = bus.i_zero_flag;
        end else if (s1_move) begin
            s1_full_d = 1'b0;
        end
    end

    always_comb begin
        s2_full_d = s2_full_q;
        exp_d     = exp_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (s1_move) begin
            s2_full_d = 1'b1;
            exp_d     = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            if (!s1_q.zero) begin
                if (raw_s >= RAW_SAT) begin
                    exp_d = '1;
                    ovf_d = 1'b1;
                end else if (raw_s <= 0) begin
                    unf_d = 1'b1;
                end else begin
                    exp_d = raw_s[SIZE_EXP-1:0];
                end
            end
        end else if (s2_move) begin
            s2_full_d = 1'b0;
        end
    end

    // A set on the transfer cycle wins over a simultaneous clear.
    assign sticky_ovf_d = (sticky_ovf_q & !bus.i_clr_sticky) | (s2_move & ovf_q);
    assign sticky_unf_d = (sticky_unf_q & !bus.i_clr_sticky) | (s2_move & unf_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_full_q    <= 1'b0;
            s2_full_q    <= 1'b0;
            s1_q         <= '0;
            exp_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            s1_full_q    <= s1_full_d;
            s2_full_q    <= s2_full_d;
            s1_q         <= s1_d;
            exp_q        <= exp_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_valid      = s2_full_q;
    assign bus.o_exp_result = exp_q;
    assign bus.o_ovf        = ovf_q;
    assign bus.o_unf        = unf_q;
    assign bus.o_sticky_ovf = sticky_ovf_q;
    assign bus.o_sticky_unf = sticky_unf_q;

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// Scoreboard bench for exp_adjust_pipe with SIZE_EXP = SIZE_LOPD = 8.
module tb_exp_adjust_pipe;

    typedef struct {
        logic [7:0] e;
        logic [7:0] l;
        logic       ov;
        logic       un;
        logic       z;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    exp_adjust_pipe_if #(.SIZE_EXP(8), .SIZE_LOPD(8)) bus ();

    exp_adjust_pipe #(.SIZE_EXP(8), .SIZE_LOPD(8)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    function automatic logic [9:0] model(input op_t o);
        int raw;
        if (o.ov)      raw = int'(o.e) + 1;
        else if (o.un) raw = int'(o.e);
        else           raw = int'(o.e) - int'(o.l);
        if (o.z)        return 10'h000;
        if (raw >= 255) return {8'hFF, 2'b10};
        if (raw <= 0)   return {8'h00, 2'b01};
        return {raw[7:0], 2'b00};
    endfunction

    function automatic op_t mk(input logic [7:0] e, input logic [7:0] l,
                               input logic ov, input logic un, input logic z);
        op_t o;
        o.e = e; o.l = l; o.ov = ov; o.un = un; o.z = z;
        return o;
    endfunction

    task automatic drive(input op_t o);
        bus.i_exp_value  = o.e;
        bus.i_lopd_value = o.l;
        bus.i_overflow   = o.ov;
        bus.i_underflow  = o.un;
        bus.i_zero_flag  = o.z;
    endtask

    function automatic logic [9:0] got_out();
        return {bus.o_exp_result, bus.o_ovf, bus.o_unf};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_clr_sticky = 1'b0;
        drive(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        #12;
        vecs++;
        if ({bus.o_valid, bus.o_exp_result, bus.o_ovf, bus.o_unf,
             bus.o_sticky_ovf, bus.o_sticky_unf} !== 13'h0) begin
            errs++;
            $display("FAIL reset_outputs got v=%b r=%h o=%b u=%b so=%b su=%b want all 0",
                     bus.o_valid, bus.o_exp_result, bus.o_ovf, bus.o_unf,
                     bus.o_sticky_ovf, bus.o_sticky_unf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.o_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready got %b want 1", bus.o_ready);
        end
    endtask

    task automatic test_basic();
        op_t o;
        logic [9:0] exp;
        o = mk(8'h80, 8'h03, 1'b0, 1'b0, 1'b0);
        q.delete();
        @(negedge clk);
        drive(o);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        q.push_back(model(o));
        @(negedge clk);
        bus.i_valid = 1'b0;
        vecs++;
        if (bus.o_valid !== 1'b0) begin
            errs++;
            $display("FAIL basic_latency1 got o_valid=%b want 0", bus.o_valid);
        end
        @(negedge clk);
        vecs++;
        if (bus.o_valid !== 1'b1 || q.size() == 0) begin
            errs++;
            $display("FAIL basic_latency2 got o_valid=%b want 1", bus.o_valid);
        end else begin
            exp = q.pop_front();
            vecs++;
            if (got_out() !== exp || exp !== {8'h7D, 2'b00}) begin
                errs++;
                $display("FAIL basic_result got %h want %h", got_out(), exp);
            end
        end
        @(negedge clk);
        vecs++;
        if (bus.o_valid !== 1'b0) begin
            errs++;
            $display("FAIL basic_drain got o_valid=%b want 0", bus.o_valid);
        end
    endtask

    task automatic test_table();
        op_t ops[10];
        logic [9:0] exp;
        ops[0] = mk(8'h80, 8'h03, 1'b0, 1'b0, 1'b0);
        ops[1] = mk(8'hFE, 8'h00, 1'b1, 1'b0, 1'b0);
        ops[2] = mk(8'h7F, 8'h09, 1'b1, 1'b1, 1'b0);
        ops[3] = mk(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        ops[4] = mk(8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
        ops[5] = mk(8'h40, 8'h00, 1'b0, 1'b0, 1'b1);
        ops[6] = mk(8'h10, 8'h07, 1'b0, 1'b1, 1'b0);
        ops[7] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        ops[8] = mk(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0);
        ops[9] = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        q.delete();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.o_valid !== ((i >= 2) && (i < 12))) begin
                errs++;
                $display("FAIL table_valid cyc %0d got %b", i, bus.o_valid);
            end
            if (bus.o_valid === 1'b1 && q.size() != 0) begin
                exp = q.pop_front();
                vecs++;
                if (got_out() !== exp) begin
                    errs++;
                    $display("FAIL table_result cyc %0d got %h want %h", i, got_out(), exp);
                end
            end
            if (i < 10) begin
                drive(ops[i]);
                bus.i_valid = 1'b1;
                vecs++;
                if (bus.o_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL table_ready cyc %0d got %b want 1", i, bus.o_ready);
                end
                q.push_back(model(ops[i]));
            end else begin
                bus.i_valid = 1'b0;
            end
        end
        vecs++;
        if (bus.o_sticky_ovf !== 1'b1 || bus.o_sticky_unf !== 1'b1) begin
            errs++;
            $display("FAIL table_sticky got ovf=%b unf=%b want 1 1",
                     bus.o_sticky_ovf, bus.o_sticky_unf);
        end
        bus.i_clr_sticky = 1'b1;
        @(negedge clk);
        bus.i_clr_sticky = 1'b0;
        vecs++;
        if (bus.o_sticky_ovf !== 1'b0 || bus.o_sticky_unf !== 1'b0) begin
            errs++;
            $display("FAIL table_clr got ovf=%b unf=%b want 0 0",
                     bus.o_sticky_ovf, bus.o_sticky_unf);
        end
    endtask

    task automatic test_stall();
        op_t ops[8];
        logic [9:0] exp, prev_got;
        logic prev_hold;
        int sent, cyc;
        for (int k = 0; k < 8; k++) begin
            ops[k] = mk(8'($urandom_range(20, 250)), 8'($urandom_range(0, 15)),
                        1'b0, 1'b0, 1'b0);
        end
        q.delete();
        sent = 0;
        cyc = 0;
        prev_hold = 1'b0;
        prev_got = '0;
        while ((sent < 8 || q.size() != 0) && cyc < 80) begin
            @(negedge clk);
            bus.i_ready = (cyc % 3 == 0);
            #1;
            vecs++;
            if (bus.o_ready !== !(q.size() == 2 && !bus.i_ready)) begin
                errs++;
                $display("FAIL stall_ready cyc %0d got %b occ %0d", cyc, bus.o_ready, q.size());
            end
            if (prev_hold) begin
                vecs++;
                if (bus.o_valid !== 1'b1 || got_out() !== prev_got) begin
                    errs++;
                    $display("FAIL stall_hold cyc %0d got %h want %h", cyc, got_out(), prev_got);
                end
            end
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL stall_extra cyc %0d got %h want none", cyc, got_out());
                end else begin
                    exp = q.pop_front();
                    if (got_out() !== exp) begin
                        errs++;
                        $display("FAIL stall_result cyc %0d got %h want %h", cyc, got_out(), exp);
                    end
                end
            end
            prev_hold = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
            prev_got = got_out();
            if (sent < 8) begin
                drive(ops[sent]);
                bus.i_valid = 1'b1;
                if (bus.o_ready === 1'b1) begin
                    q.push_back(model(ops[sent]));
                    sent++;
                end
            end else begin
                bus.i_valid = 1'b0;
            end
            cyc++;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        vecs++;
        if (sent != 8 || q.size() != 0) begin
            errs++;
            $display("FAIL stall_timeout got sent=%0d pending=%0d want 8 0", sent, q.size());
        end
    endtask

    task automatic test_reset_mid();
        op_t o;
        o = mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        q.delete();
        @(negedge clk);
        bus.i_ready = 1'b0;
        drive(o);
        bus.i_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        vecs++;
        if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_full got o_valid=%b o_ready=%b want 1 0",
                     bus.o_valid, bus.o_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.o_valid !== 1'b0) begin
            errs++;
            $display("FAIL mid_async got o_valid=%b want 0", bus.o_valid);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.o_valid !== 1'b0 || bus.o_sticky_ovf !== 1'b0) begin
                errs++;
                $display("FAIL mid_discard cyc %0d got o_valid=%b sticky=%b want 0 0",
                         i, bus.o_valid, bus.o_sticky_ovf);
            end
        end
    endtask

    task automatic test_sticky_clr();
        logic [9:0] exp;
        op_t o;
        o = mk(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        q.delete();
        bus.i_ready = 1'b1;
        drive(o);
        bus.i_valid = 1'b1;
        q.push_back(model(o));
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.o_valid !== 1'b1 || q.size() == 0) begin
            errs++;
            $display("FAIL clr_valid got o_valid=%b want 1", bus.o_valid);
        end else begin
            exp = q.pop_front();
            vecs++;
            if (got_out() !== exp) begin
                errs++;
                $display("FAIL clr_result got %h want %h", got_out(), exp);
            end
        end
        bus.i_clr_sticky = 1'b1;
        @(negedge clk);
        bus.i_clr_sticky = 1'b0;
        vecs++;
        if (bus.o_sticky_unf !== 1'b1 || bus.o_sticky_ovf !== 1'b0) begin
            errs++;
            $display("FAIL clr_set_wins got unf=%b ovf=%b want 1 0",
                     bus.o_sticky_unf, bus.o_sticky_ovf);
        end
        bus.i_clr_sticky = 1'b1;
        @(negedge clk);
        bus.i_clr_sticky = 1'b0;
        vecs++;
        if (bus.o_sticky_unf !== 1'b0) begin
            errs++;
            $display("FAIL clr_plain got unf=%b want 0", bus.o_sticky_unf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_stall();
        test_reset_mid();
        test_sticky_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/exp_adjust_pipe.md
EXP_ADJUST_PIPE -- requirements
Module: exp_adjust_pipe

Interface
REQ-001 SHALL have parameter SIZE_EXP, 8, exponent width in bits (legal range 4..11).
REQ-002 SHALL have parameter SIZE_LOPD, 8, leading-one-position shift-amount width (must be SIZE_LOPD <= SIZE_EXP).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port i_valid, input, 1, upstream operand valid.
REQ-006 SHALL have port o_ready, output, 1, block can accept an operand this cycle.
REQ-007 SHALL have port i_overflow, input, 1, mantissa carried out; exponent +1.
REQ-008 SHALL have port i_underflow, input, 1, no normalisation shift; exponent unchanged.
REQ-009 SHALL have port i_zero_flag, input, 1, mantissa result is zero.
REQ-010 SHALL have port i_lopd_value, input, SIZE_LOPD, left-shift amount to subtract.
REQ-011 SHALL have port i_exp_value, input, SIZE_EXP, biased pre-normalisation exponent.
REQ-012 SHALL have port o_valid, output, 1, result valid.
REQ-013 SHALL have port i_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port o_exp_result, output, SIZE_EXP, adjusted, saturated exponent.
REQ-015 SHALL have ports o_ovf and o_unf, output, 1 each, per-result exponent-overflow / exponent-underflow flags, valid with o_valid.
REQ-016 SHALL have port i_clr_sticky, input, 1, synchronous clear of sticky flags.
REQ-017 SHALL have ports o_sticky_ovf and o_sticky_unf, output, 1 each, sticky OR of every accepted o_ovf / o_unf.

Function
REQ-018 SHALL be a 2-stage pipeline: S1 registers a signed SIZE_EXP+2-bit raw exponent; S2 registers the saturated result and flags; latency from accepted input to o_valid is 2 cycles when i_ready held high.
REQ-019 S1 raw value SHALL be: i_exp_value+1 if i_overflow; else i_exp_value if i_underflow; else i_exp_value-i_lopd_value (zero-extended operands, no wrap).
REQ-020 i_overflow SHALL take priority over i_underflow when both are high.
REQ-021 S2 SHALL produce: i_zero_flag (carried from S1) -> result 0, o_ovf=0, o_unf=0; raw >= 2^SIZE_EXP-1 -> result all-ones, o_ovf=1; raw <= 0 -> result 0, o_unf=1; otherwise result = raw[SIZE_EXP-1:0], both flags 0.
REQ-022 An input transfer SHALL occur when i_valid && o_ready; an output transfer when o_valid && i_ready.
REQ-023 Each stage SHALL load when it is empty or its contents move on this cycle; o_ready = !S1_full || S1 moves to S2 this cycle (S2 empty or S2 transferring).
REQ-024 While o_valid && !i_ready, o_exp_result/o_ovf/o_unf SHALL hold stable.
REQ-025 Simultaneous input and output transfers SHALL sustain one result per cycle with no bubble and no loss.
REQ-026 Sticky flags SHALL set on the output-transfer cycle of a result with o_ovf/o_unf; i_clr_sticky SHALL clear them, and a set in the same cycle SHALL win over clear.
REQ-027 o_ready SHALL not depend combinationally on i_valid.

Reset
REQ-028 On i_rst_n low: both stages empty, o_valid=0, o_exp_result=0, o_ovf=0, o_unf=0, o_sticky_ovf=0, o_sticky_unf=0; o_ready=1 after reset releases.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operands with no output transfer.

Structure
REQ-030 A shared package SHALL hold the BFP16 constants (exponent width 8, mantissa width 7, all-ones exponent) and a struct for the S1 payload (raw exponent, zero flag).
REQ-031 The S1 add/subtract SHALL be one sub-module, cla_nbit, a SIZE_EXP+2-bit carry-lookahead adder generalising the existing 8-bit CLA.

Verification
REQ-032 exp=0x80, lopd=3, flags 0, i_ready=1 -> two cycles later o_exp_result=0x7D, o_ovf=0, o_unf=0.
REQ-033 exp=0xFE, i_overflow=1 -> result 0xFF, o_ovf=1, o_sticky_ovf=1 after transfer; exp=0x7F with i_overflow=1 and i_underflow=1 -> 0x80.
REQ-034 exp=0x03, lopd=5 -> result 0x00, o_unf=1; exp=0x05, lopd=5 -> 0x00, o_unf=1; exp=0x40, i_zero_flag=1 -> 0x00, no flags.
REQ-035 Stream of 8 operands with i_ready toggled 1,0,0,1,... -> all 8 results in order, unchanged while stalled, o_ready low only when both stages full and stalled.
REQ-036 Assert i_rst_n=0 with both stages full -> o_valid drops asynchronously, no sticky set; i_clr_sticky with simultaneous o_unf transfer -> o_sticky_unf stays 1.
